// File: rtl/mips_ctrl_pkg.sv
// Shared pipeline-control types and constants for the mips_32 hazard sequencer.
package mips_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } seq_state_e;

  localparam int REG_ZERO         = 0;
  localparam int MULT_CYCLES_DEF  = 4;
  localparam int DIV_CYCLES_DEF   = 32;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_hold;
    logic muldiv_start;
    logic muldiv_busy;
  } ctrl_t;

  localparam ctrl_t CTRL_NOMINAL = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/muldiv_timer.sv
// Loadable down-counter holding the remaining WAIT cycles of a mult/div operation.
module muldiv_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (load)
      wait_cnt <= load_value;
    else if (dec && wait_cnt != '0)
      wait_cnt <= wait_cnt - 1'b1;
  end

  assign zero = (wait_cnt == '0);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline-control sequencer: load-use bubbles, branch/jump flushes and
// freezing the pipeline for fixed-latency mult/div operations.
module hazard_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_is_mult,
  input  logic                  id_is_div,
  input  logic                  id_branch_taken,
  input  logic                  id_jump,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_hold,
  output logic                  muldiv_start,
  output logic                  muldiv_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int WAIT_W  = ($clog2(MAX_LAT) > 6) ? $clog2(MAX_LAT) : 6;

  // WAIT lasts LAT-1 cycles and exits on zero, so the timer is loaded with LAT-2.
  localparam logic [WAIT_W-1:0] MULT_LOAD = WAIT_W'((MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0);
  localparam logic [WAIT_W-1:0] DIV_LOAD  = WAIT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

  seq_state_e        state, state_nx;
  ctrl_t             ctrl;
  logic              load_use;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;
  logic [WAIT_W-1:0] tmr_load_val;

  assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  muldiv_timer #(.W(WAIT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .dec        (tmr_dec),
    .load_value (tmr_load_val),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= RUN;
    else
      state <= state_nx;
  end

  always_comb begin
    ctrl         = CTRL_NOMINAL;
    state_nx     = state;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = '0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (load_use) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
          end else if (id_is_div) begin
            ctrl.muldiv_start = 1'b1;
            if (DIV_CYCLES > 1) begin
              state_nx     = WAIT;
              tmr_load     = 1'b1;
              tmr_load_val = DIV_LOAD;
            end
          end else if (id_is_mult) begin
            ctrl.muldiv_start = 1'b1;
            if (MULT_CYCLES > 1) begin
              state_nx     = WAIT;
              tmr_load     = 1'b1;
              tmr_load_val = MULT_LOAD;
            end
          end else if (id_branch_taken || id_jump) begin
            ctrl.if_id_flush = 1'b1;
          end
        end
        WAIT: begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.ex_hold     = 1'b1;
          ctrl.muldiv_busy = 1'b1;
          if (tmr_zero)
            state_nx = RUN;
          else
            tmr_dec = 1'b1;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_hold      = ctrl.ex_hold;
  assign muldiv_start = ctrl.muldiv_start;
  assign muldiv_busy  = ctrl.muldiv_busy;

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (!pc_write && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed table, corner sequences, random vs model.
module tb_hazard_sequencer;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;
  localparam int STALL_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, id_is_mult, id_is_div, id_branch_taken, id_jump, ex_mem_read;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, muldiv_start, muldiv_busy;
  logic [15:0] stall_count;

  hazard_sequencer #(
    .REG_ADDR_W  (5),
    .MULT_CYCLES (MULT_LAT),
    .DIV_CYCLES  (DIV_LAT),
    .CNT_W       (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_is_mult      (id_is_mult),
    .id_is_div       (id_is_div),
    .id_branch_taken (id_branch_taken),
    .id_jump         (id_jump),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_hold         (ex_hold),
    .muldiv_start    (muldiv_start),
    .muldiv_busy     (muldiv_busy),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, rd;
    logic       uses_rt, mult, div, br, jmp, rd_mem;
  } in_t;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       uses_rt, rd_mem, br, jmp;
    logic [6:0] exp;
  } vec_t;

  // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, muldiv_start, muldiv_busy
  localparam logic [6:0] NOM   = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] FLUSH = 7'b1110000;
  localparam logic [6:0] START = 7'b1100010;
  localparam logic [6:0] BUSY  = 7'b0000101;

  int passed = 0;
  int total  = 0;

  // Reference model: cycles of WAIT still owed and cycles stalled so far.
  int m_busy  = 0;
  int m_stall = 0;

  int          s_cnt;
  logic [6:0]  got;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic in_t idle();
    in_t v;
    v.rst = 1'b0; v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3;
    v.uses_rt = 1'b0; v.mult = 1'b0; v.div = 1'b0;
    v.br = 1'b0; v.jmp = 1'b0; v.rd_mem = 1'b0;
    return v;
  endfunction

  function automatic logic [6:0] model_out(input in_t v);
    bit lu;
    if (v.rst) return NOM;
    if (m_busy > 0) return BUSY;
    lu = v.rd_mem && v.rd != 0 && (v.rd == v.rs || (v.uses_rt && v.rd == v.rt));
    if (lu) return STALL;
    if (v.mult || v.div) return START;
    if (v.br || v.jmp) return FLUSH;
    return NOM;
  endfunction

  task automatic model_advance(input in_t v, input logic [6:0] e);
    if (v.rst) begin
      m_busy = 0;
      m_stall = 0;
    end else begin
      if (m_busy > 0) m_busy--;
      else if (e[1]) m_busy = (v.div ? DIV_LAT : MULT_LAT) - 1;
      if (!e[6] && m_stall < STALL_MAX) m_stall++;
    end
  endtask

  task automatic step(input in_t v, input string name, output logic [6:0] o);
    logic [6:0] e;
    @(negedge clk);
    reset = v.rst; id_rs = v.rs; id_rt = v.rt; ex_rd = v.rd;
    id_uses_rt = v.uses_rt; id_is_mult = v.mult; id_is_div = v.div;
    id_branch_taken = v.br; id_jump = v.jmp; ex_mem_read = v.rd_mem;
    #1;
    o = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, muldiv_start, muldiv_busy};
    s_cnt = int'(stall_count);
    e = model_out(v);
    chk({name, " outputs"}, int'(o), int'(e));
    chk({name, " stall_count"}, s_cnt, m_stall);
    model_advance(v, e);
  endtask

  task automatic do_reset();
    in_t v;
    v = idle();
    v.rst = 1'b1;
    v.rd_mem = 1'b1; v.rd = 5'd1; v.div = 1'b1;
    step(v, "reset", got);
    chk("reset forces nominal", int'(got), int'(NOM));
  endtask

  vec_t tbl[10];
  in_t  v;
  int   busy;

  initial begin
    tbl[0] = '{rs:9,  rt:2,  rd:9,  uses_rt:0, rd_mem:1, br:0, jmp:0, exp:STALL};
    tbl[1] = '{rs:9,  rt:2,  rd:9,  uses_rt:0, rd_mem:0, br:0, jmp:0, exp:NOM};
    tbl[2] = '{rs:0,  rt:4,  rd:0,  uses_rt:0, rd_mem:1, br:0, jmp:0, exp:NOM};
    tbl[3] = '{rs:3,  rt:12, rd:12, uses_rt:0, rd_mem:1, br:0, jmp:0, exp:NOM};
    tbl[4] = '{rs:3,  rt:12, rd:12, uses_rt:1, rd_mem:1, br:0, jmp:0, exp:STALL};
    tbl[5] = '{rs:3,  rt:4,  rd:6,  uses_rt:1, rd_mem:1, br:1, jmp:0, exp:FLUSH};
    tbl[6] = '{rs:3,  rt:4,  rd:6,  uses_rt:0, rd_mem:0, br:0, jmp:1, exp:FLUSH};
    tbl[7] = '{rs:5,  rt:4,  rd:5,  uses_rt:0, rd_mem:1, br:1, jmp:0, exp:STALL};
    tbl[8] = '{rs:5,  rt:4,  rd:5,  uses_rt:0, rd_mem:0, br:1, jmp:0, exp:FLUSH};
    tbl[9] = '{rs:8,  rt:7,  rd:7,  uses_rt:1, rd_mem:1, br:0, jmp:1, exp:STALL};

    reset = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 1'b0;
    id_is_mult = 1'b0; id_is_div = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0; ex_mem_read = 1'b0;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = idle();
      v.rs = tbl[i].rs; v.rt = tbl[i].rt; v.rd = tbl[i].rd; v.uses_rt = tbl[i].uses_rt;
      v.rd_mem = tbl[i].rd_mem; v.br = tbl[i].br; v.jmp = tbl[i].jmp;
      step(v, $sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d table", i), int'(got), int'(tbl[i].exp));
      if (i == 1) chk("stall_count after one load-use", s_cnt, 1);
    end
    v = idle();
    step(v, "after jump", got);
    chk("single jump flush", int'(got[4]), 0);

    // DIV then MULT occupancy
    do_reset();
    v = idle(); v.div = 1'b1;
    step(v, "div start", got);
    chk("div start pulse", int'(got), int'(START));
    v = idle(); busy = 0;
    for (int i = 0; i < 40; i++) begin
      step(v, "div wait", got);
      if (!got[0]) break;
      busy++;
    end
    chk("div busy cycles", busy, DIV_LAT - 1);
    chk("div end nominal", int'(got), int'(NOM));
    chk("stall_count after div", s_cnt, 31);
    v = idle(); v.mult = 1'b1;
    step(v, "mult start", got);
    chk("mult start pulse", int'(got), int'(START));
    v = idle(); busy = 0;
    for (int i = 0; i < 10; i++) begin
      step(v, "mult wait", got);
      if (!got[0]) break;
      busy++;
    end
    chk("mult busy cycles", busy, MULT_LAT - 1);
    chk("stall_count after mult", s_cnt, 34);

    // Reset on the 10th DIV busy cycle
    do_reset();
    v = idle(); v.div = 1'b1;
    step(v, "div2 start", got);
    v = idle();
    for (int i = 0; i < 9; i++) step(v, "div2 wait", got);
    chk("9th busy cycle", int'(got), int'(BUSY));
    v.rst = 1'b1;
    step(v, "reset mid wait", got);
    chk("nominal during reset in wait", int'(got), int'(NOM));
    v = idle();
    step(v, "after reset", got);
    chk("busy cleared after reset", int'(got[0]), 0);
    chk("stall_count cleared after reset", s_cnt, 0);

    // Back-to-back MULT
    do_reset();
    v = idle(); v.mult = 1'b1;
    step(v, "b2b start1", got);
    chk("b2b first start", int'(got[1]), 1);
    for (int i = 0; i < 3; i++) step(v, "b2b wait", got);
    step(v, "b2b start2", got);
    chk("b2b second start", int'(got), int'(START));
    v = idle();
    for (int i = 0; i < 4; i++) step(v, "b2b drain", got);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.rst     = ($urandom_range(0, 199) == 0);
      v.rs      = 5'($urandom_range(0, 7));
      v.rt      = 5'($urandom_range(0, 7));
      v.rd      = 5'($urandom_range(0, 7));
      v.uses_rt = 1'($urandom);
      v.rd_mem  = ($urandom_range(0, 2) == 0);
      v.mult    = ($urandom_range(0, 19) == 0);
      v.div     = ($urandom_range(0, 59) == 0);
      v.br      = ($urandom_range(0, 5) == 0);
      v.jmp     = ($urandom_range(0, 7) == 0);
      step(v, $sformatf("rand%0d", n), got);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central pipeline-control sequencer for the 5-stage mips_32 core.
- Detects load-use data hazards and inserts a one-cycle bubble.
- Sequences flushes for taken branches and jumps, which resolve in ID.
- Freezes the pipeline while the iterative multiply/divide unit runs a fixed-latency operation.
- Drives the write enables of the PC and pipeline registers. Sits beside the forwarding unit; forwarding itself stays outside this block.

Parameters:
REG_ADDR_W, 5, register-specifier width
MULT_CYCLES, 4, total EX occupancy of MULT in cycles (>=1)
DIV_CYCLES, 32, total EX occupancy of DIV in cycles (>=1)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high reset
id_rs  in  REG_ADDR_W  rs of instruction in ID
id_rt  in  REG_ADDR_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_is_mult  in  1  ID instruction is MULT
id_is_div  in  1  ID instruction is DIV
id_branch_taken  in  1  branch in ID resolved taken
id_jump  in  1  ID instruction is J/JAL/JR
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination register of EX instruction
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register load enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  load NOP into ID/EX
ex_hold  out  1  hold ID/EX contents; EX/MEM receives NOP
muldiv_start  out  1  one-cycle start pulse to the mult/div unit
muldiv_busy  out  1  sequencer is in WAIT
stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- States: RUN, WAIT. Counter wait_cnt (6 bits minimum) counts down.
- Outputs are combinational from state and inputs (Mealy), except stall_count, which is registered.
- Nominal outputs: pc_write=1, if_id_write=1, all other 1-bit outputs 0.
- Reset: state=RUN, wait_cnt=0, stall_count=0.
  - While reset=1, every output is forced to its nominal value, regardless of inputs.
  - Reset in WAIT aborts the operation; the cycle after reset deasserts is RUN with nominal outputs.
- load_use = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- Priority in RUN, highest first:
  1. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. Branch, jump and muldiv in ID are not acted on this cycle; they are re-evaluated next cycle with the same ID instruction.
  2. id_is_mult or id_is_div, with LAT = MULT_CYCLES or DIV_CYCLES respectively:
     - Assert muldiv_start=1 for one cycle; the instruction advances into EX normally.
     - If LAT>1: next state=WAIT, wait_cnt=LAT-2.
     - If LAT==1: stay in RUN.
     - id_is_mult and id_is_div both set is illegal; DIV wins.
  3. id_branch_taken or id_jump: if_id_flush=1 for one cycle; pc_write=1.
- WAIT, every cycle:
  - pc_write=0, if_id_write=0, ex_hold=1, muldiv_busy=1.
  - id_ex_bubble=0, if_id_flush=0, muldiv_start=0.
  - All ID-side inputs are ignored.
  - If wait_cnt==0, next state=RUN; otherwise decrement wait_cnt.
  - WAIT therefore lasts exactly LAT-1 cycles.
  - The first RUN cycle after WAIT evaluates ID normally, so back-to-back muldivs are allowed.
- stall_count increments on every cycle (reset=0) with pc_write==0, and saturates at 2^CNT_W-1.
- Register index 0 never creates a hazard.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state encoding (RUN, WAIT);
  - REG_ZERO;
  - MULT_CYCLES and DIV_CYCLES defaults;
  - a nominal-control-output constant.
- Sub-module muldiv_timer: a loadable down-counter with load, load_value, and a zero flag. It is instantiated once and owns wait_cnt.

Test Plan:
1. Load-use on rs: ex_mem_read=1, ex_rd=9, id_rs=9.
   - Cycle 1: pc_write=0, if_id_write=0, id_ex_bubble=1.
   - Cycle 2 (ex_mem_read=0): all outputs nominal; stall_count=1.
2. Zero and rt filtering:
   - ex_rd=0, id_rs=0 -> no stall.
   - ex_rd=12, id_rt=12, id_uses_rt=0 -> no stall.
   - Same with id_uses_rt=1 -> one-cycle stall.
3. DIV with DIV_CYCLES=32: id_is_div=1 -> muldiv_start=1 for 1 cycle, then exactly 31 cycles of muldiv_busy=1/ex_hold=1/pc_write=0, then nominal outputs; stall_count=31. Repeat with MULT -> 3 busy cycles; stall_count=34.
4. Branch coincident with load-use: id_branch_taken=1, ex_mem_read=1, ex_rd=id_rs=5.
   - Cycle 1: stall, if_id_flush=0.
   - Cycle 2 (ex_mem_read=0): if_id_flush=1, pc_write=1.
   - id_jump alone -> exactly one flush cycle.
5. Reset mid-WAIT: assert reset on the 10th DIV busy cycle for 1 cycle. During reset, outputs are nominal. The next cycle is RUN with muldiv_busy=0 and stall_count=0.
6. Back-to-back MULT: keep id_is_mult=1 -> a second muldiv_start arrives on the first cycle after the 3 busy cycles; no cycle is lost.
